// File: rtl/drfm_cmd_sync.sv
// DRFM command synchroniser: captures the virtual-JTAG command word at Update-DR (tck)
// and hands it to the clk domain over a toggle req/ack handshake, then decodes it.
module drfm_cmd_sync #(
  parameter int DR_W        = 49,
  parameter int SYNC_STAGES = 2,
  parameter int DROP_W      = 8
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              tck,
  input  logic [DR_W-1:0]   dr_word,
  input  logic              udr,
  input  logic              ir_sel,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              cmd_valid,
  output logic [3:0]        mode,
  output logic [9:0]        delay_q,
  output logic [8:0]        doppler_q,
  output logic [8:0]        scale_q,
  output logic [16:0]       load_data,
  output logic              load_strobe
);

  // Field layout of the command word, MSB first.
  typedef struct packed {
    logic        ld_en;
    logic [16:0] load;
    logic        scl_en;
    logic [8:0]  scale;
    logic        dop_en;
    logic [8:0]  doppler;
    logic        dly_en;
    logic [9:0]  delay;
  } cmd_t;

  // ---------------- tck domain ----------------
  logic                   udr_d;
  logic                   req_t;
  logic [DR_W-1:0]        hold_reg;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_t;
  logic                   cap, accept, drop;
  logic                   req_t_nxt, ack_s_nxt;

  assign cap       = udr & ~udr_d & ir_sel;
  assign accept    = cap & ~busy;
  assign drop      = cap & busy;
  assign req_t_nxt = req_t ^ accept;
  assign ack_s_nxt = ack_sync[SYNC_STAGES-2];

  // busy is the registered req/ack comparison, so a cap on the edge where ack
  // lands still sees busy=1 and is dropped.
  always_ff @(posedge tck or posedge aclr) begin
    if (aclr) begin
      udr_d    <= 1'b0;
      req_t    <= 1'b0;
      busy     <= 1'b0;
      hold_reg <= '0;
      ack_sync <= '0;
      drop_cnt <= '0;
    end else begin
      udr_d    <= udr;
      req_t    <= req_t_nxt;
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_t};
      busy     <= (req_t_nxt != ack_s_nxt);
      if (accept)
        hold_reg <= dr_word;
      if (drop && (drop_cnt != {DROP_W{1'b1}}))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // ---------------- clk domain ----------------
  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s, req_d, new_cmd;
  cmd_t                   w;

  assign req_s   = req_sync[SYNC_STAGES-1];
  assign new_cmd = req_s ^ req_d;
  // hold_reg is frozen while a transfer is pending, so it is read directly.
  assign w       = cmd_t'(hold_reg[$bits(cmd_t)-1:0]);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      req_sync    <= '0;
      req_d       <= 1'b0;
      ack_t       <= 1'b0;
      cmd_valid   <= 1'b0;
      load_strobe <= 1'b0;
      mode        <= 4'b0000;
      delay_q     <= '0;
      doppler_q   <= '0;
      scale_q     <= '0;
      load_data   <= '0;
    end else begin
      req_sync    <= {req_sync[SYNC_STAGES-2:0], req_t};
      req_d       <= req_s;
      cmd_valid   <= new_cmd;
      load_strobe <= 1'b0;
      if (new_cmd) begin
        ack_t <= req_s;
        if (w.dly_en) begin
          delay_q <= w.delay;
          mode    <= 4'b0001;
        end else if (w.dop_en) begin
          doppler_q <= w.doppler;
          mode      <= 4'b1000;
        end else if (w.scl_en) begin
          scale_q <= w.scale;
          mode    <= 4'b0010;
        end else if (w.ld_en) begin
          load_data   <= w.load;
          mode        <= 4'b0100;
          load_strobe <= 1'b1;
        end else begin
          mode <= 4'b0000;
        end
      end
    end
  end

endmodule

// File: doc/drfm_cmd_sync.md
Name: drfm_cmd_sync

Overview:
Downstream stage of the virtual-JTAG shift register. Captures the 49-bit command word at Update-DR in the tck domain and carries it into the 100 MHz system clock domain with a toggle request/acknowledge handshake. Decodes the word into registered DRFM parameter outputs: delay, doppler, scale and load data, plus a one-hot mode code for the seven-segment display. Also counts commands that are dropped because a transfer is still in flight.

Parameters:
DR_W, 49, command word width
SYNC_STAGES, 2, synchroniser flop count in each crossing direction (minimum 2)
DROP_W, 8, width of the saturating drop counter

Ports:
clk  in  1  100 MHz system clock (M100CLK)
aclr  in  1  reset aclr, asynchronous, active-high; clears both domains
tck  in  1  virtual JTAG test clock
dr_word  in  DR_W  shifted data register, tck domain
udr  in  1  virtual_state_udr, tck domain
ir_sel  in  1  high when the instruction register selects the command DR (all ir_in bits set)
busy  out  1  tck domain; a transfer is pending
drop_cnt  out  DROP_W  tck domain; saturating count of dropped commands
cmd_valid  out  1  clk domain; one-cycle pulse when a new command is applied
mode  out  4  clk domain; 0001 delay, 1000 doppler, 0010 scale, 0100 load, 0000 idle
delay_q  out  10  clk domain
doppler_q  out  9  clk domain
scale_q  out  9  clk domain
load_data  out  17  clk domain
load_strobe  out  1  clk domain; one-cycle pulse that accompanies a load command

Behaviour:
- Reset: every output and internal flop goes to 0 in both domains, including hold_reg, the req/ack toggles and the synchroniser chains.
- A transfer in flight when aclr asserts is discarded and no cmd_valid is issued for it.
- tck domain, Update-DR detect:
  - udr_d registers udr.
  - cap = udr & ~udr_d & ir_sel.
- tck domain, on cap with busy=0:
  - hold_reg <= dr_word.
  - req_t toggles.
  - busy <= 1.
- tck domain, on cap with busy=1:
  - hold_reg, req_t and busy are unchanged.
  - drop_cnt increments and saturates at all-ones.
- tck domain, ack return:
  - ack_t passes through SYNC_STAGES tck flops to give ack_s.
  - busy = (req_t != ack_s).
  - busy clears only after tck has toggled enough to synchronise ack; the host driver must clock tck after Update-DR, for example by idling in Run-Test/Idle.
- clk domain, request detect:
  - req_t passes through SYNC_STAGES flops to give req_s; req_d registers req_s.
  - new = req_s ^ req_d.
  - hold_reg is stable while busy=1, so it is sampled directly on new and is exempt from synchronisation.
- clk domain, at the edge where new=1, with registered outputs:
  - Decode with priority: bit10, then bit20, then bit30, then bit48.
  - bit10=1: delay_q <= w[9:0], mode <= 0001.
  - else bit20=1: doppler_q <= w[19:11], mode <= 1000.
  - else bit30=1: scale_q <= w[29:21], mode <= 0010.
  - else bit48=1: load_data <= w[47:31], mode <= 0100, load_strobe <= 1.
  - else: mode <= 0000 and all parameter registers hold.
  - In every case: cmd_valid <= 1 and ack_t <= req_t (the synchronised value).
- cmd_valid and load_strobe are high for exactly one clk cycle.
- Parameter registers hold between commands.
- mode holds its last value until the next command.
- Latency: cmd_valid rises on the (SYNC_STAGES+1)-th clk rising edge after req_t toggles, counting the first clk edge that samples the new value. With SYNC_STAGES=2 this is 3 edges, plus up to 1 cycle of metastability uncertainty.
- The handshake is four-phase-free (toggle), so back-to-back commands are spaced by the round trip only.
- Simultaneous cap and ack arrival on the same tck edge:
  - ack clears busy combinationally, but cap is judged against the registered busy of that edge.
  - The command is therefore dropped.
  - busy is implemented as the registered comparison, and drop behaviour follows that comparison.
- At most one command is in flight; there is no queue.
- tck stopping never corrupts the clk domain. A stalled ack only holds busy high.

Test Plan:
- Reset then idle: both clocks running, aclr pulsed mid-run -> all outputs 0, busy=0, drop_cnt=0, no cmd_valid.
- Delay command: ir_sel=1, dr_word bit10=1 with [9:0]=0x2A5, udr pulse -> busy=1; cmd_valid pulses once 3 clk edges after req_t sync; delay_q=0x2A5, mode=0001; busy returns 0 after the ack sync.
- Priority: word with bits 10, 20 and 48 set and [9:0]=0x001 -> only delay_q=0x001 updates, mode=0001, load_strobe stays 0.
- Load command: bit48=1, [47:31]=0x1ABCD, others clear -> load_data=0x1ABCD, mode=0100, load_strobe high for 1 clk coinciding with cmd_valid.
- Overrun: second udr pulse while busy=1 with scale word -> scale_q unchanged, drop_cnt=1. Send 300 overruns -> drop_cnt saturates at 255.
- Reset mid-transfer: aclr asserted 1 clk after req_t toggles -> no cmd_valid. After release, a fresh doppler word with [19:11]=0x155 yields doppler_q=0x155, mode=1000.
